// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchroniser, start-bit qualification at mid-bit,
// LSB-first mid-bit sampling, one-cycle data-valid and framing-error strobes.
//
// state        | meaning
// S_IDLE       | line idle; waiting for synchronised line to go low
// S_START      | counting to the start-bit midpoint to reject glitches
// S_DATA       | sampling 8 data bits, one per bit period
// S_STOP       | sampling the stop bit; deliver byte or flag framing error
// S_BREAK_WAIT | stop bit was low; hold off start detection until line is high
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Busy,
    output logic       o_Frame_Err
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_STOP       = 3'd3,
        S_BREAK_WAIT = 3'd4
    } state_t;

    logic          rx_meta_q;
    logic          rx_s_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          dv_q;
    logic          ferr_q;
    logic          busy_q;

    // Line idles high, so the synchroniser resets high to avoid a false start.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    busy_q <= 1'b0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= S_DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Leaving at the stop midpoint gives IDLE half a bit of margin
                // before a back-to-back start bit can reach rx_s.
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            byte_q  <= shift_q;
                            dv_q    <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_BREAK_WAIT: begin
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_RX_Busy   = busy_q;
    assign o_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at 16 clocks per bit: directed scenarios plus random and
// exhaustive byte traffic from a behavioural serial transmitter.
module tb_uart_rx_core;

    localparam int CPB     = 16;
    localparam int HALF    = (CPB - 1) / 2;
    localparam int LATENCY = 2 + HALF + 9 * CPB + 1;
    localparam int FRAME   = 10 * CPB;

    logic       clk;
    logic       rst_b;
    logic       rx_line;
    logic       dv;
    logic [7:0] rx_byte;
    logic       busy;
    logic       ferr;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int low_cyc = 0;
    int dv_cnt = 0;
    int ferr_cnt = 0;
    logic busy_seen = 1'b0;
    logic [7:0] exp_q[$];
    int dv_cyc_q[$];

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_b),
        .i_RX_Serial (rx_line),
        .o_RX_DV     (dv),
        .o_RX_Byte   (rx_byte),
        .o_RX_Busy   (busy),
        .o_Frame_Err (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every DV must match the next expected byte at the expected latency.
    always @(negedge clk) begin
        if (rst_b) begin
            n_cmp++;
            assert (!(dv && ferr)) else begin
                n_fail++;
                $error("FAIL dv_ferr_overlap: observed dv=%0b ferr=%0b expected not both", dv, ferr);
            end
            if (busy) busy_seen = 1'b1;
            if (ferr) ferr_cnt++;
            if (dv) begin
                dv_cnt++;
                dv_cyc_q.push_back(cyc);
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL dv_unexpected: observed byte %0h expected no DV", rx_byte);
                end
                if (exp_q.size() > 0) begin
                    check("dv_byte", rx_byte, exp_q.pop_front());
                    check("dv_latency", cyc - low_cyc, LATENCY);
                end
            end
        end
    end

    // Behavioural transmitter: start, 8 data LSB first, stop; drives the first nbits.
    task automatic send(input logic [7:0] d, input logic stop_bit, input int nbits);
        logic [9:0] frame;
        frame = {stop_bit, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_line = frame[i];
            if (i == 0) low_cyc = cyc + 1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        int dv0;
        int f0;
        int lows;
        logic [7:0] b;
        rst_b   = 1'b0;
        rx_line = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dv", dv, 1'b0);
        check("rst_byte", rx_byte, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        rst_b = 1'b1;
        repeat (10) @(negedge clk);

        // Single good byte
        dv0 = dv_cnt; f0 = ferr_cnt;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 10);
        repeat (4) @(negedge clk);
        check("a5_dv_count", dv_cnt - dv0, 1);
        check("a5_byte", rx_byte, 8'hA5);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_busy_after", busy, 1'b0);

        // Short low glitch on idle line
        dv0 = dv_cnt; f0 = ferr_cnt;
        busy_seen = 1'b0;
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_dv", dv_cnt - dv0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_byte", rx_byte, 8'hA5);

        // Framing error followed by a held-low break
        dv0 = dv_cnt; f0 = ferr_cnt;
        send(8'h3C, 1'b0, 10);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) lows++;
        end
        check("break_busy_held", lows, 0);
        check("ferr_count", ferr_cnt - f0, 1);
        check("ferr_no_dv", dv_cnt - dv0, 0);
        check("ferr_byte_kept", rx_byte, 8'hA5);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("break_exit_busy", busy, 1'b0);
        check("break_exit_dv", dv_cnt - dv0, 0);
        check("break_exit_ferr", ferr_cnt - f0, 1);

        // Back-to-back frames with no idle gap
        dv0 = dv_cnt;
        dv_cyc_q.delete();
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h81);
        send(8'h00, 1'b1, 10);
        send(8'hFF, 1'b1, 10);
        send(8'h81, 1'b1, 10);
        repeat (4) @(negedge clk);
        check("b2b_dv_count", dv_cnt - dv0, 3);
        check("b2b_byte_last", rx_byte, 8'h81);
        if (dv_cyc_q.size() == 3) begin
            check("b2b_gap1", dv_cyc_q[1] - dv_cyc_q[0], FRAME);
            check("b2b_gap2", dv_cyc_q[2] - dv_cyc_q[1], FRAME);
        end

        // Reset during data bit 4
        dv0 = dv_cnt; f0 = ferr_cnt;
        send(8'h55, 1'b1, 5);
        rx_line = 1'b1;
        repeat (8) @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_dv", dv, 1'b0);
        check("midrst_byte", rx_byte, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ferr", ferr, 1'b0);
        rst_b = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_dv", dv_cnt - dv0, 0);
        check("abort_no_ferr", ferr_cnt - f0, 0);
        exp_q.push_back(8'h0F);
        send(8'h0F, 1'b1, 10);
        repeat (4) @(negedge clk);
        check("after_rst_dv", dv_cnt - dv0, 1);
        check("after_rst_byte", rx_byte, 8'h0F);

        // Random bytes with random idle gaps
        dv0 = dv_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send(b, 1'b1, 10);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("rand_dv_count", dv_cnt - dv0, 20);
        check("rand_ferr", ferr_cnt - f0, 0);

        // Loopback of every byte value
        dv0 = dv_cnt; f0 = ferr_cnt;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            exp_q.push_back(b);
            send(b, 1'b1, 10);
        end
        repeat (4) @(negedge clk);
        check("loop_dv_count", dv_cnt - dv0, 256);
        check("loop_ferr", ferr_cnt - f0, 0);
        check("loop_last_byte", rx_byte, 8'hFF);
        check("exp_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver; the receive counterpart to the team's UART transmitter, sharing its CLKS_PER_BIT bit timing.
- Synchronises the asynchronous serial line, detects and qualifies the start bit, and samples each bit at mid-period, LSB first.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the command/FIFO logic.

Parameters:
- CLKS_PER_BIT, 217, i_Clock cycles per serial bit; legal range ≥4. HALF = (CLKS_PER_BIT-1)/2, integer division.

Ports:
- i_Clock  input  1  system clock.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_RX_Serial  input  1  raw serial line; idles high; asynchronous to i_Clock.
- o_RX_DV  output  1  one-cycle strobe; o_RX_Byte is valid while it is high.
- o_RX_Byte  output  8  last good received byte; held until the next good byte.
- o_RX_Busy  output  1  high from start detect until return to IDLE.
- o_Frame_Err  output  1  one-cycle strobe; stop bit sampled low.

Behaviour:
- Reset (asynchronous, i_Rst_L=0): state=IDLE, counter=0, bit index=0, shift register=0, synchroniser flops=1. Outputs: o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Busy=0, o_Frame_Err=0.
- Reset mid-frame aborts the frame with no DV and no error. Reception restarts on the next falling edge after release.
- Synchroniser: two flops on i_RX_Serial, giving rx_s. All decisions use rx_s, adding 2 cycles of input latency.
- Counter width: $clog2(CLKS_PER_BIT)+1 bits. Counter clears on every state change and every bit boundary.
- IDLE: o_RX_Busy=0. On rx_s==0, go to START with counter=0 and o_RX_Busy=1.
- START: counter increments each cycle. When counter==HALF, sample rx_s.
  - rx_s==0: valid start; go to DATA with counter=0 and index=0.
  - rx_s==1: glitch; return to IDLE with no strobes.
- DATA: counter increments. When counter==CLKS_PER_BIT-1, sample rx_s into shift[index] (LSB first) and clear counter.
  - index<7: increment index.
  - index==7: go to STOP.
- STOP: when counter==CLKS_PER_BIT-1, sample rx_s.
  - 1: on the same edge, load o_RX_Byte with the shift register and pulse o_RX_DV for one cycle; go to IDLE.
  - 0: pulse o_Frame_Err for one cycle. o_RX_Byte is unchanged and no DV is issued. Go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering start detection. o_RX_Busy stays 1.
- o_RX_DV and o_Frame_Err are never high together. Both default to 0 every cycle.
- Latency: the DV edge is 2 + HALF + 9*CLKS_PER_BIT + 1 cycles after the first i_RX_Serial low. All samples land at mid-bit ±1 cycle.
- Back-to-back frames: a start bit beginning immediately after the stop mid-sample (≥HALF cycles of stop left) must be caught. IDLE is re-entered before the next falling edge can reach rx_s.
- Encodings outside the defined states go to IDLE.

Test Plan (CLKS_PER_BIT=16, HALF=7, bit period 16 clocks):
- Reset, line high, then send 8'hA5 → exactly one o_RX_DV pulse with o_RX_Byte=8'hA5, o_Frame_Err never high, o_RX_Busy low afterwards.
- Low glitch of 5 clocks on the idle line → o_RX_Busy pulses high then returns low by the HALF check; no DV, no Frame_Err, o_RX_Byte unchanged.
- Send 8'h3C with stop bit driven 0, then hold the line low 40 clocks before raising it → one o_Frame_Err pulse, no DV, o_RX_Byte keeps its previous value; state stays BREAK_WAIT until the line rises; no new start detected during the low hold.
- Back-to-back 8'h00, 8'hFF, 8'h81 with zero idle gap → three DV pulses carrying 00, FF, 81 in order, each 160 clocks apart.
- Assert i_Rst_L=0 during data bit 4 of 8'h55, release, then send 8'h0F → no DV for the aborted frame; outputs at reset values during reset; next DV carries 8'h0F.
- Transmitter loopback: connect the team's transmitter to this block at matching CLKS_PER_BIT and send all 256 values → every received byte equals the sent byte, with zero framing errors.
